// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// One request/response pair in flight at a time, valid/ready on both channels.
interface ifetch_unit_if;
  logic        ifu_o_req_valid;
  logic [31:0] ifu_o_req_addr;
  logic        ifu_i_req_ready;
  logic        ifu_i_rsp_valid;
  logic [31:0] ifu_i_rsp_data;
  logic        ifu_i_rsp_err;
  logic        ifu_o_rsp_ready;

  modport master (
    output ifu_o_req_valid,
    output ifu_o_req_addr,
    input  ifu_i_req_ready,
    input  ifu_i_rsp_valid,
    input  ifu_i_rsp_data,
    input  ifu_i_rsp_err,
    output ifu_o_rsp_ready
  );

  modport slave (
    input  ifu_o_req_valid,
    input  ifu_o_req_addr,
    output ifu_i_req_ready,
    output ifu_i_rsp_valid,
    output ifu_i_rsp_data,
    output ifu_i_rsp_err,
    input  ifu_o_rsp_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one memory request at a time and presents
// the fetched instruction to decode, honouring regF stall and execute-stage redirects.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl_i_regF_stall,
  input  logic                execute_i_need_jump,
  input  logic [31:0]         execute_i_jump_pc,
  ifetch_unit_if.master       mem,
  output logic                fetch_o_valid,
  output logic [31:0]         fetch_o_pc,
  output logic [31:0]         fetch_o_inst,
  output logic                fetch_o_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        stale_q, stale_d;
  logic [31:0] cap_pc_q, cap_pc_d;
  logic [31:0] cap_inst_q, cap_inst_d;
  logic        cap_err_q, cap_err_d;

  logic [31:0] jump_tgt;
  logic        unused_jump_lsb;

  assign jump_tgt        = {execute_i_jump_pc[31:2], 2'b00};
  assign unused_jump_lsb = ^execute_i_jump_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    stale_d    = stale_q;
    cap_pc_d   = cap_pc_q;
    cap_inst_d = cap_inst_q;
    cap_err_d  = cap_err_q;

    if (execute_i_need_jump) begin
      pc_d = jump_tgt;
    end

    unique case (state_q)
      StIdle: begin
        state_d    = StReq;
        req_addr_d = execute_i_need_jump ? jump_tgt : pc_q;
      end
      StReq: begin
        // Address stays put until accepted; a redirect only marks the fetch stale.
        if (mem.ifu_i_req_ready) begin
          state_d = StWait;
        end
        if (execute_i_need_jump) begin
          stale_d = 1'b1;
        end
      end
      StWait: begin
        if (mem.ifu_i_rsp_valid) begin
          if (stale_q || execute_i_need_jump) begin
            stale_d    = 1'b0;
            req_addr_d = execute_i_need_jump ? jump_tgt : pc_q;
            state_d    = StReq;
          end else begin
            cap_pc_d   = req_addr_q;
            cap_inst_d = mem.ifu_i_rsp_data;
            cap_err_d  = mem.ifu_i_rsp_err;
            state_d    = StHold;
          end
        end else if (execute_i_need_jump) begin
          stale_d = 1'b1;
        end
      end
      StHold: begin
        if (execute_i_need_jump) begin
          req_addr_d = jump_tgt;
          state_d    = StReq;
        end else if (!ctrl_i_regF_stall) begin
          pc_d       = cap_pc_q + 32'd4;
          req_addr_d = cap_pc_q + 32'd4;
          state_d    = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      stale_q    <= 1'b0;
      cap_pc_q   <= RESET_PC;
      cap_inst_q <= NOP_INST;
      cap_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      stale_q    <= stale_d;
      cap_pc_q   <= cap_pc_d;
      cap_inst_q <= cap_inst_d;
      cap_err_q  <= cap_err_d;
    end
  end

  assign mem.ifu_o_req_valid = (state_q == StReq);
  assign mem.ifu_o_req_addr  = req_addr_q;
  assign mem.ifu_o_rsp_ready = (state_q == StWait);
  assign fetch_o_valid       = (state_q == StHold);
  assign fetch_o_pc          = cap_pc_q;
  assign fetch_o_inst        = cap_inst_q;
  assign fetch_o_err         = cap_err_q;

endmodule
